bam_dot_accumulator: RTL
========================

Name: bam_dot_accumulator

Overview:
- Sequential stage directly downstream of the 8x8 unsigned approximate broken-array multipliers.
- Consumes a stream of 16-bit approximate products over a valid/ready handshake and sums a programmed number of them into a saturating accumulator.
- Returns one dot-product result per job over a second valid/ready handshake.
- Used to measure and apply approximate-multiplier error at the dot-product level.

Parameters:
- PROD_W, 16, width of each incoming product.
- ACC_W, 24, accumulator and result width; must be >= PROD_W.
- LEN_W, 8, width of the job-length field; a job is at most 2^LEN_W-1 products.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  job request, sampled only in IDLE.
- len  input  LEN_W  number of products in the job, sampled with start.
- in_valid  input  1  product beat valid.
- in_ready  output  1  accumulator accepts a product this cycle.
- in_prod  input  PROD_W  unsigned product, zero-extended to ACC_W.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_acc  output  ACC_W  accumulated sum.
- out_ovf  output  1  sticky flag: saturation occurred during this job.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; acc=0; cnt=0; len_q=0; ovf=0.
  - All outputs 0: in_ready, out_valid, out_acc, out_ovf, busy.
- States: IDLE, ACCUM, HOLD (encoding in package).
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1: latch len_q=len, clear acc, cnt and ovf.
  - len!=0 -> ACCUM. len==0 -> HOLD with acc=0.
- ACCUM:
  - in_ready=1 combinationally from state only; no dependence on in_valid.
  - A beat is in_valid & in_ready.
  - On each beat: acc <= sat(acc + zext(in_prod)); cnt <= cnt+1.
  - If the true sum exceeds 2^ACC_W-1: acc <= all-ones and ovf <= 1. ovf stays set until the next job start.
  - Beat with cnt == len_q-1 is the last -> HOLD next cycle.
  - No beat -> state and acc unchanged; bubbles are legal.
- HOLD:
  - out_valid=1, out_acc=acc, out_ovf=ovf, in_ready=0.
  - Outputs are stable while out_ready=0.
  - On out_ready=1 -> IDLE. acc is not cleared, so out_acc keeps the last value in IDLE but out_valid=0.
- Latency:
  - Result is valid on the cycle after the final accepted beat.
  - A len=0 job is valid the cycle after start.
  - Minimum job turnaround: len+2 cycles with in_valid held high and out_ready held high.
- start outside IDLE is ignored, including start in the same cycle as the HOLD handoff. A new job needs start asserted while in IDLE.
- in_prod is not checked for sparsity. All PROD_W bits are added even though the upstream multiplier ties low bits to zero.
- Reset mid-job: immediate return to reset state. The partial sum is discarded and no result is produced.
- Width rule: ACC_W < PROD_W is illegal; flag it with an elaboration-time assertion.

Decomposition:
- Shared package bam_acc_pkg holds:
  - state enum: IDLE, ACCUM, HOLD;
  - default widths: PROD_W, ACC_W, LEN_W;
  - function sat_add(acc, prod) returning {ovf, sum}.
- One natural sub-module, bam_sat_adder: combinational ACC_W saturating adder with carry-out as the ovf source. FSM, counter and registers stay in the top.

Test Plan:
- Reset/idle: rst_n low mid-ACCUM after 2 beats -> all outputs 0 immediately; after release, start len=1 with prod=16'h3800 -> out_acc=24'h003800, out_ovf=0.
- Basic job: start len=4, products 16'h0800, 16'h1000, 16'h7800, 16'h4000 back-to-back -> out_valid 1 cycle after 4th beat, out_acc=24'h00D000.
- Backpressure/bubbles:
  - in_valid toggled 1,0,1,0 with len=3 -> exactly 3 beats counted.
  - out_ready held 0 for 5 cycles -> out_acc stable, in_ready=0.
  - out_ready then 1 -> IDLE next cycle.
- Saturation: ACC_W=16, len=2, products 16'hF000, 16'h2000 -> out_acc=16'hFFFF, out_ovf=1; next job len=1 prod=16'h0800 -> out_ovf=0.
- Zero length: start len=0 -> HOLD next cycle, out_acc=0, no beat accepted even with in_valid=1.
- Illegal start: start pulsed during ACCUM and during the HOLD->IDLE handoff -> ignored, len_q unchanged, busy drops to 0 after the handoff.

Source files
------------

// File: rtl/bam_acc_pkg.sv
// Shared types, default widths and reference saturating-add helper for the
// approximate-product dot-product accumulator.
package bam_acc_pkg;

    localparam int DEF_PROD_W = 16;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_LEN_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } acc_state_e;

    // Returns {ovf, sum}; sum clamps to all-ones when the true sum does not fit.
    function automatic logic [DEF_ACC_W:0] sat_add(
        input logic [DEF_ACC_W-1:0]  acc,
        input logic [DEF_PROD_W-1:0] prod
    );
        logic [DEF_ACC_W:0] raw;
        raw = {1'b0, acc} + (DEF_ACC_W+1)'(prod);
        if (raw[DEF_ACC_W]) begin
            return {1'b1, {DEF_ACC_W{1'b1}}};
        end
        return raw;
    endfunction

endpackage

// File: rtl/bam_dot_accumulator_if.sv
// Job control, product stream and result handshake of the dot-product accumulator.
interface bam_dot_accumulator_if
    import bam_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic              out_ovf;
    logic              busy;

    modport master (
        output start, len, in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf, busy
    );

    modport slave (
        input  start, len, in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_acc, out_ovf, busy
    );
endinterface

// File: rtl/bam_sat_adder.sv
// Combinational saturating adder: zero-extended product added to the running
// sum, with the carry-out acting as the overflow indicator.
module bam_sat_adder #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);
    logic [ACC_W:0] raw;

    assign raw   = {1'b0, acc_i} + (ACC_W+1)'(prod_i);
    assign ovf_o = raw[ACC_W];
    assign sum_o = ovf_o ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
endmodule

// File: rtl/bam_dot_accumulator.sv
// Sums a programmed number of approximate products into a saturating
// accumulator and hands back one result per job.
module bam_dot_accumulator
    import bam_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    bam_dot_accumulator_if.slave bus
);
    if (ACC_W < PROD_W) begin : g_width_check
        $error("bam_dot_accumulator: ACC_W (%0d) must be >= PROD_W (%0d)", ACC_W, PROD_W);
    end

    acc_state_e        state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  len_q;
    logic              ovf_q;

    logic              beat;
    logic              last_beat;
    logic [ACC_W-1:0]  sum_d;
    logic              add_ovf;

    assign beat      = bus.in_valid && (state_q == ST_ACCUM);
    assign last_beat = (cnt_q == len_q - LEN_W'(1));

    bam_sat_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_sat_adder (
        .acc_i  (acc_q),
        .prod_i (bus.in_prod),
        .sum_o  (sum_d),
        .ovf_o  (add_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        len_q   <= bus.len;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= (bus.len != '0) ? ST_ACCUM : ST_HOLD;
                    end
                end
                ST_ACCUM: begin
                    if (beat) begin
                        acc_q <= sum_d;
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (add_ovf) begin
                            ovf_q <= 1'b1;
                        end
                        if (last_beat) begin
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // Start in the handoff cycle is dropped: only IDLE samples it.
                    if (bus.out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // acc_q persists after handoff, so out_acc still shows the last result in IDLE.
    assign bus.in_ready  = (state_q == ST_ACCUM);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_acc   = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule
